serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor: the inverse operation of the N-bit ripple-carry adder.
//  Computes A - B one bit per clock, LSB first, through a single full-subtractor cell,
//  rippling the borrow through a register. Trades n cycles of latency for one cell of area.
//  Sits beside the adders in the arithmetic library. Uses valid/ready on both sides.
// PARAMETERS
//  n   4   operand width in bits; legal range n >= 1
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    A/B operands valid
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  A          in   n    minuend
//  B          in   n    subtrahend
//  out_valid  out  1    diff is valid; held until consumed
//  out_ready  in   1    consumer accepts diff
//  diff       out  n+1  {borrow_out, (A-B) mod 2^n}; borrow_out=1 iff A<B (unsigned)
// BEHAVIOUR
//  Reset (sampled at rising edge): state=IDLE, in_ready=1, out_valid=0, diff=0,
//    bit counter=0, borrow reg=0. Reset wins over every other event, any state.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. If in_valid=1 at edge E0: latch A,B into shift regs,
//     borrow=0, cnt=0, clear diff, go to RUN. Otherwise stay in IDLE.
//   RUN: in_ready=0. Each cycle, bit i=cnt:
//     d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
//     Write d into diff[i]; borrow<=bout; cnt<=cnt+1.
//     On cnt==n-1: write diff[n]=bout, go to DONE.
//   DONE: out_valid=1, diff stable. If out_ready=1 at an edge: out_valid<=0 and go to IDLE.
//     in_ready stays 0 in DONE; there is no same-cycle overlap of
//     output consumption and next-operand acceptance.
//  Latency: out_valid rises after edge E0+n; minimum throughput is one result per n+2 cycles.
//  Inputs A/B are ignored outside the IDLE acceptance edge; changing them mid-RUN has no effect.
//  in_valid is ignored in RUN/DONE; an operand source must hold it until in_ready.
//  n=1: RUN lasts exactly one cycle; counter width = max(1,$clog2(n)); no wrap of cnt past n-1.
//  Reset mid-RUN or mid-DONE: the partial result is discarded and out_valid drops the cycle after reset.
//  out_ready while out_valid=0 is ignored.
//  diff[n-1:0] is bit-identical to (A - B) mod 2^n. diff == {A<B, A-B} for all unsigned A, B.
// STRUCTURE
//  Shared package arith_pkg: state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    and a CNT_W(n) width function. Reuse both in any future serial arithmetic block.
//  One sub-module: full_subtractor (outputs bout,d; inputs a,b,bin), combinational.
//  Top: FSM, operand shift regs (shift right per RUN cycle), borrow reg, cnt, diff reg.
// TESTING
//  n=4: A=5, B=3 -> after n cycles, diff=5'b0_0010, out_valid=1.
//  n=4: A=3, B=5 -> diff=5'b1_1110 (borrow set).
//  n=4: A=4'hF,B=0 -> 5'b0_1111. A=0,B=4'hF -> 5'b1_0001. A=B=9 -> 5'b0_0000.
//  Backpressure: out_ready=0 for 5 cycles -> diff/out_valid held, in_ready=0;
//    out_ready=1 -> IDLE the next cycle.
//  Reset asserted on RUN cycle 2 -> next cycle IDLE, out_valid=0, diff=0; new op (7-2) -> 5'b0_0101.
//  n=1 and n=8 builds: exhaustive or 1000 random A/B vs reference model {A<B, A-B}.
//    Check latency is exactly n for every result.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: controller state encoding
// and the bit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    // A 1-bit operand still needs a 1-bit counter, so clamp the width at 1.
    function automatic int CNT_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell with a registered borrow.
// diff = {A<B, (A-B) mod 2^n}, presented with valid/ready on both sides.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for in_valid to latch operands
//  RUN   | one operand bit per cycle through the cell, cnt = bit index
//  DONE  | out_valid high, diff held until out_ready
module serial_ripple_subtractor
    import arith_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n:0]   diff
);

    localparam int CW = CNT_W(n);

    arith_state_t  state, state_nxt;
    logic [n-1:0]  a_sh, b_sh;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic [n:0]    diff_r, diff_nxt;
    logic          d, bout, last;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt == CW'(n - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit cnt of the result takes the cell's difference; the final borrow lands in the MSB.
    always_comb begin
        diff_nxt = diff_r;
        for (int i = 0; i < n; i++) begin
            if (cnt == CW'(i)) diff_nxt[i] = d;
        end
        if (last) diff_nxt[n] = bout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        diff_r <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bout;
                    diff_r <= diff_nxt;
                    if (!last) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed checks of serial_ripple_subtractor at n=4 (main), n=1 and n=8.
module tb_serial_ripple_subtractor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       iv4 = 0, ir4, ov4, or4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic [4:0] d4;
    logic       iv1 = 0, ir1, ov1, or1 = 0;
    logic [0:0] a1 = 0, b1 = 0;
    logic [1:0] d1;
    logic       iv8 = 0, ir8, ov8, or8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic [8:0] d8;

    int n_cmp = 0;
    int n_err = 0;

    serial_ripple_subtractor #(.n(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .diff(d4));
    serial_ripple_subtractor #(.n(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(or1), .diff(d1));
    serial_ripple_subtractor #(.n(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input int w);
        return (w == 1) ? ov1 : (w == 4) ? ov4 : ov8;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 1) ? ir1 : (w == 4) ? ir4 : ir8;
    endfunction

    function automatic logic [8:0] get_diff(input int w);
        return (w == 1) ? {7'd0, d1} : (w == 4) ? {4'd0, d4} : d8;
    endfunction

    task automatic drive(input int w, input logic iv, input logic [7:0] a, input logic [7:0] b);
        case (w)
            1: begin iv1 = iv; a1 = a[0:0]; b1 = b[0:0]; end
            4: begin iv4 = iv; a4 = a[3:0]; b4 = b[3:0]; end
            default: begin iv8 = iv; a8 = a; b8 = b; end
        endcase
    endtask

    task automatic set_or(input int w, input logic v);
        case (w)
            1: or1 = v;
            4: or4 = v;
            default: or8 = v;
        endcase
    endtask

    // Launch one operation, scramble operands mid-RUN, measure latency, check result.
    // Leaves the DUT in DONE unless consume is set.
    task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] exp, input string tag, input bit consume);
        int cyc;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        check({tag, "_in_ready"}, 32'(get_ir(w)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, ~a, ~b);
        cyc = 0;
        while (!get_ov(w) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(w));
        check({tag, "_diff"}, 32'(get_diff(w)), 32'(exp));
        if (consume) begin
            set_or(w, 1'b1);
            @(negedge clk);
            set_or(w, 1'b0);
            check({tag, "_ov_drop"}, 32'(get_ov(w)), 32'd0);
            check({tag, "_idle"}, 32'(get_ir(w)), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ir4", 32'(ir4), 32'd1);
        check("rst_ov4", 32'(ov4), 32'd0);
        check("rst_d4", 32'(d4), 32'd0);
        check("rst_ir1", 32'(ir1), 32'd1);
        check("rst_d8", 32'(d8), 32'd0);
        reset = 1'b0;

        // out_ready while idle must not matter
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check("idle_or_ov4", 32'(ov4), 32'd0);

        start_op(4, 8'd5,  8'd3,  9'h002, "n4_5m3", 1);
        start_op(4, 8'd3,  8'd5,  9'h01E, "n4_3m5", 1);
        start_op(4, 8'hF,  8'd0,  9'h00F, "n4_Fm0", 1);
        start_op(4, 8'd0,  8'hF,  9'h011, "n4_0mF", 1);
        start_op(4, 8'd9,  8'd9,  9'h000, "n4_9m9", 1);

        // Backpressure: result held, no new operand accepted while in DONE
        start_op(4, 8'd12, 8'd6, 9'h006, "n4_bp", 0);
        drive(4, 1'b1, 8'd1, 8'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ov", 32'(ov4), 32'd1);
            check("bp_ir", 32'(ir4), 32'd0);
            check("bp_diff", 32'(d4), 32'h006);
        end
        drive(4, 1'b0, 8'd0, 8'd0);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check("bp_release_ov", 32'(ov4), 32'd0);
        check("bp_release_ir", 32'(ir4), 32'd1);

        // Reset during RUN cycle 2 discards the partial result
        @(negedge clk);
        drive(4, 1'b1, 8'd5, 8'd3);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 8'd0, 8'd0);
        check("mid_run_ir", 32'(ir4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_run_ov", 32'(ov4), 32'd0);
        check("rst_run_ir", 32'(ir4), 32'd1);
        check("rst_run_diff", 32'(d4), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_run_stay_idle", 32'(ov4), 32'd0);
        start_op(4, 8'd7, 8'd2, 9'h005, "n4_7m2", 1);

        // Reset while holding a result in DONE
        start_op(4, 8'd2, 8'd7, 9'h01B, "n4_2m7", 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_done_ov", 32'(ov4), 32'd0);
        check("rst_done_diff", 32'(d4), 32'd0);

        // n=1, exhaustive
        start_op(1, 8'd0, 8'd0, 9'h000, "n1_0m0", 1);
        start_op(1, 8'd1, 8'd0, 9'h001, "n1_1m0", 1);
        start_op(1, 8'd0, 8'd1, 9'h003, "n1_0m1", 1);
        start_op(1, 8'd1, 8'd1, 9'h000, "n1_1m1", 1);

        // n=8, directed
        start_op(8, 8'd200, 8'd100, 9'h064, "n8_200m100", 1);
        start_op(8, 8'd100, 8'd200, 9'h19C, "n8_100m200", 1);
        start_op(8, 8'd0,   8'd1,   9'h1FF, "n8_0m1", 1);
        start_op(8, 8'hFF,  8'd0,   9'h0FF, "n8_FFm0", 1);
        start_op(8, 8'h80,  8'h7F,  9'h001, "n8_80m7F", 1);
        start_op(8, 8'hAA,  8'h55,  9'h055, "n8_AAm55", 1);
        start_op(8, 8'h55,  8'hAA,  9'h1AB, "n8_55mAA", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
